motor_cmd_sched: RTL and testbench



---
 rtl/motor_cmd_pkg.sv | 78 +++++++
 rtl/duty_ramp.sv | 57 +++++
 rtl/motor_cmd_sched.sv | 225 ++++++++++++++++++++++
 tb/tb_motor_cmd_sched.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/motor_cmd_pkg.sv
// Shared encodings for the motor command scheduler: FSM states, command and
// acknowledgement bytes, LED codes and the command decoder.
package motor_cmd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RAMP  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_BRAKE = 2'd3
  } state_t;

  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_A = 8'h41;
  localparam logic [7:0] CMD_S = 8'h53;
  localparam logic [7:0] CMD_D = 8'h44;
  localparam logic [7:0] CMD_X = 8'h58;

  localparam logic [7:0] ACK_UNKNOWN = 8'h3F;
  localparam logic [7:0] ACK_WDOG    = 8'h21;

  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;

  localparam logic [4:0] LED_X = 5'b10000;
  localparam logic [4:0] LED_W = 5'b01000;
  localparam logic [4:0] LED_A = 5'b00100;
  localparam logic [4:0] LED_S = 5'b00010;
  localparam logic [4:0] LED_D = 5'b00001;

  typedef struct packed {
    logic       known;
    logic       keep_dir;
    logic       dir;
    logic [7:0] tgt_l;
    logic [7:0] tgt_r;
    logic [4:0] led;
    logic [7:0] ack;
  } cmd_t;

  // Bit 5 is masked so lower-case letters decode like upper case.
  function automatic cmd_t decode_cmd(input logic [7:0] rx, input logic [7:0] duty_max);
    cmd_t       c;
    logic [7:0] up;
    logic [7:0] quarter;
    logic [7:0] half;
    up      = rx & 8'hDF;
    quarter = {2'b00, duty_max[7:2]};
    half    = {1'b0, duty_max[7:1]};
    c       = '0;
    case (up)
      CMD_W: begin
        c.known = 1'b1; c.dir = DIR_FWD; c.tgt_l = duty_max; c.tgt_r = duty_max;
        c.led = LED_W; c.ack = CMD_W;
      end
      CMD_A: begin
        c.known = 1'b1; c.dir = DIR_FWD; c.tgt_l = quarter; c.tgt_r = duty_max;
        c.led = LED_A; c.ack = CMD_A;
      end
      CMD_D: begin
        c.known = 1'b1; c.dir = DIR_FWD; c.tgt_l = duty_max; c.tgt_r = quarter;
        c.led = LED_D; c.ack = CMD_D;
      end
      CMD_S: begin
        c.known = 1'b1; c.keep_dir = 1'b1; c.tgt_l = 8'd0; c.tgt_r = 8'd0;
        c.led = LED_S; c.ack = CMD_S;
      end
      CMD_X: begin
        c.known = 1'b1; c.dir = DIR_REV; c.tgt_l = half; c.tgt_r = half;
        c.led = LED_X; c.ack = CMD_X;
      end
      default: begin
        c.ack = ACK_UNKNOWN;
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/duty_ramp.sv
// One PWM channel's duty register, slewed toward its target by a fixed step
// on every ramp tick, landing exactly on the target without overshoot.
module duty_ramp #(
  parameter int DUTY_STEP = 5
) (
  input  logic       clk_50M,
  input  logic       rst_n,
  input  logic       i_tick,
  input  logic [7:0] i_target,
  output logic [7:0] o_duty,
  output logic       o_at_target
);

  localparam logic [7:0] L_STEP = DUTY_STEP[7:0];

  logic [7:0] r_duty;
  logic [7:0] w_gap;
  logic [7:0] w_next;

  // Next duty: one step toward the target, or the target itself when closer than a step.
  always_comb begin
    w_gap  = 8'd0;
    w_next = r_duty;
    if (i_target > r_duty) begin
      w_gap = i_target - r_duty;
      if (w_gap < L_STEP) begin
        w_next = i_target;
      end else begin
        w_next = r_duty + L_STEP;
      end
    end else if (i_target < r_duty) begin
      w_gap = r_duty - i_target;
      if (w_gap < L_STEP) begin
        w_next = i_target;
      end else begin
        w_next = r_duty - L_STEP;
      end
    end else begin
      w_next = r_duty;
    end
  end

  // Duty register advances only on ramp ticks.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      r_duty <= 8'd0;
    end else if (i_tick) begin
      r_duty <= w_next;
    end else begin
      r_duty <= r_duty;
    end
  end

  assign o_duty      = r_duty;
  assign o_at_target = (r_duty == i_target);

endmodule

// File: rtl/motor_cmd_sched.sv
// Drive-command scheduler: decodes UART command bytes, ramps two PWM duties
// with brake-before-reverse, enforces a receive watchdog and queues acks.
module motor_cmd_sched
  import motor_cmd_pkg::*;
#(
  parameter int RAMP_DIV    = 500000,
  parameter int DUTY_STEP   = 5,
  parameter int DUTY_MAX    = 100,
  parameter int WDOG_CYCLES = 25000000
) (
  input  logic       clk_50M,
  input  logic       rst_n,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_valid,
  input  logic       i_tx_ready,
  output logic [7:0] o_tx_data,
  output logic       o_tx_start,
  output logic [7:0] o_l_duty,
  output logic [7:0] o_r_duty,
  output logic       o_dir,
  output logic [4:0] o_led,
  output logic [1:0] o_state
);

  localparam int TICK_W = $clog2(RAMP_DIV + 1);
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(RAMP_DIV - 1);
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);
  localparam logic [WDOG_W-1:0] WDOG_FULL = WDOG_W'(WDOG_CYCLES);
  localparam logic [WDOG_W-1:0] WDOG_ONE  = WDOG_W'(1);
  localparam logic [7:0]        L_DUTY_MAX = DUTY_MAX[7:0];

  state_t            r_state;
  logic              r_dir;
  logic [7:0]        r_tgt_l;
  logic [7:0]        r_tgt_r;
  logic [7:0]        r_pend_l;
  logic [7:0]        r_pend_r;
  logic              r_pend_dir;
  logic [4:0]        r_led;
  logic [TICK_W-1:0] r_tick_cnt;
  logic [WDOG_W-1:0] r_wdog;
  logic              r_ack_pend;
  logic [7:0]        r_ack_byte;
  logic              r_tx_start;
  logic [7:0]        r_tx_data;

  cmd_t       w_cmd;
  logic       w_cmd_acc;
  logic       w_tick;
  logic       w_wdog_fire;
  logic       w_req_dir;
  logic       w_req_zero;
  logic       w_both_zero;
  logic       w_both_at;
  logic       w_tgt_zero;
  logic [7:0] w_l_duty;
  logic [7:0] w_r_duty;
  logic       w_l_at;
  logic       w_r_at;
  logic       w_ack_new;
  logic [7:0] w_ack_byte;

  assign w_cmd       = decode_cmd(i_rx_data, L_DUTY_MAX);
  assign w_cmd_acc   = i_rx_valid && w_cmd.known;
  assign w_tick      = (r_tick_cnt == TICK_LAST);
  assign w_req_dir   = w_cmd.keep_dir ? r_dir : w_cmd.dir;
  assign w_req_zero  = (w_cmd.tgt_l == 8'd0) && (w_cmd.tgt_r == 8'd0);
  assign w_both_zero = (w_l_duty == 8'd0) && (w_r_duty == 8'd0);
  assign w_both_at   = w_l_at && w_r_at;
  assign w_tgt_zero  = (r_tgt_l == 8'd0) && (r_tgt_r == 8'd0);
  // A known command arriving in the expiry cycle suppresses the watchdog.
  assign w_wdog_fire = (r_wdog == WDOG_LAST) && (r_state != ST_IDLE) && !w_cmd_acc;

  duty_ramp #(.DUTY_STEP(DUTY_STEP)) u_ramp_l (
    .clk_50M     (clk_50M),
    .rst_n       (rst_n),
    .i_tick      (w_tick),
    .i_target    (r_tgt_l),
    .o_duty      (w_l_duty),
    .o_at_target (w_l_at)
  );

  duty_ramp #(.DUTY_STEP(DUTY_STEP)) u_ramp_r (
    .clk_50M     (clk_50M),
    .rst_n       (rst_n),
    .i_tick      (w_tick),
    .i_target    (r_tgt_r),
    .o_duty      (w_r_duty),
    .o_at_target (w_r_at)
  );

  // Free-running ramp tick divider.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + TICK_ONE;
    end
  end

  // Watchdog saturates at full count so it can fire only once per silence.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      r_wdog <= '0;
    end else if (w_cmd_acc) begin
      r_wdog <= '0;
    end else if (r_wdog == WDOG_FULL) begin
      r_wdog <= r_wdog;
    end else begin
      r_wdog <= r_wdog + WDOG_ONE;
    end
  end

  // Select the acknowledgement byte produced this cycle, if any.
  always_comb begin
    w_ack_new  = 1'b0;
    w_ack_byte = 8'd0;
    if (w_cmd_acc) begin
      w_ack_new  = 1'b1;
      w_ack_byte = w_cmd.ack;
    end else if (w_wdog_fire) begin
      w_ack_new  = 1'b1;
      w_ack_byte = ACK_WDOG;
    end else if (i_rx_valid) begin
      w_ack_new  = 1'b1;
      w_ack_byte = ACK_UNKNOWN;
    end else begin
      w_ack_new  = 1'b0;
      w_ack_byte = 8'd0;
    end
  end

  // One-deep ack slot; a fresh ack bypasses the slot when the transmitter is free.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      r_ack_pend <= 1'b0;
      r_ack_byte <= 8'd0;
      r_tx_start <= 1'b0;
      r_tx_data  <= 8'd0;
    end else if ((w_ack_new || r_ack_pend) && i_tx_ready && !r_tx_start) begin
      r_tx_start <= 1'b1;
      r_tx_data  <= w_ack_new ? w_ack_byte : r_ack_byte;
      r_ack_pend <= 1'b0;
    end else begin
      r_tx_start <= 1'b0;
      if (w_ack_new) begin
        r_ack_pend <= 1'b1;
        r_ack_byte <= w_ack_byte;
      end
    end
  end

  // Scheduler FSM: targets, direction, brake pending set and LED.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_dir      <= DIR_FWD;
      r_tgt_l    <= 8'd0;
      r_tgt_r    <= 8'd0;
      r_pend_l   <= 8'd0;
      r_pend_r   <= 8'd0;
      r_pend_dir <= DIR_FWD;
      r_led      <= 5'd0;
    end else if (w_cmd_acc) begin
      r_led <= w_cmd.led;
      if ((w_req_dir != r_dir) && !w_both_zero) begin
        r_state    <= ST_BRAKE;
        r_tgt_l    <= 8'd0;
        r_tgt_r    <= 8'd0;
        r_pend_l   <= w_cmd.tgt_l;
        r_pend_r   <= w_cmd.tgt_r;
        r_pend_dir <= w_req_dir;
      end else begin
        r_state    <= ((r_state == ST_IDLE) && w_req_zero) ? ST_IDLE : ST_RAMP;
        r_dir      <= w_req_dir;
        r_tgt_l    <= w_cmd.tgt_l;
        r_tgt_r    <= w_cmd.tgt_r;
        r_pend_l   <= 8'd0;
        r_pend_r   <= 8'd0;
        r_pend_dir <= w_req_dir;
      end
    end else if (w_wdog_fire) begin
      r_state    <= ST_RAMP;
      r_tgt_l    <= 8'd0;
      r_tgt_r    <= 8'd0;
      r_pend_l   <= 8'd0;
      r_pend_r   <= 8'd0;
      r_pend_dir <= r_dir;
    end else begin
      case (r_state)
        ST_RAMP: begin
          if (w_both_at) begin
            r_state <= w_tgt_zero ? ST_IDLE : ST_HOLD;
          end
        end
        ST_BRAKE: begin
          if (w_both_zero) begin
            r_state  <= ST_RAMP;
            r_dir    <= r_pend_dir;
            r_tgt_l  <= r_pend_l;
            r_tgt_r  <= r_pend_r;
            r_pend_l <= 8'd0;
            r_pend_r <= 8'd0;
          end
        end
        default: begin
          r_state <= r_state;
        end
      endcase
    end
  end

  assign o_tx_data  = r_tx_data;
  assign o_tx_start = r_tx_start;
  assign o_l_duty   = w_l_duty;
  assign o_r_duty   = w_r_duty;
  assign o_dir      = r_dir;
  assign o_led      = r_led;
  assign o_state    = r_state;

endmodule

// File: tb/tb_motor_cmd_sched.sv
// Directed bench for motor_cmd_sched with shortened ramp and watchdog periods.
module tb_motor_cmd_sched;

  logic       clk_50M = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] i_rx_data = 8'd0;
  logic       i_rx_valid = 1'b0;
  logic       i_tx_ready = 1'b1;
  logic [7:0] o_tx_data;
  logic       o_tx_start;
  logic [7:0] o_l_duty;
  logic [7:0] o_r_duty;
  logic       o_dir;
  logic [4:0] o_led;
  logic [1:0] o_state;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk_50M = ~clk_50M;

  motor_cmd_sched #(
    .RAMP_DIV    (4),
    .DUTY_STEP   (5),
    .DUTY_MAX    (100),
    .WDOG_CYCLES (400)
  ) dut (
    .clk_50M    (clk_50M),
    .rst_n      (rst_n),
    .i_rx_data  (i_rx_data),
    .i_rx_valid (i_rx_valid),
    .i_tx_ready (i_tx_ready),
    .o_tx_data  (o_tx_data),
    .o_tx_start (o_tx_start),
    .o_l_duty   (o_l_duty),
    .o_r_duty   (o_r_duty),
    .o_dir      (o_dir),
    .o_led      (o_led),
    .o_state    (o_state)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Byte presented for exactly one rising edge; returns at the following negedge.
  task automatic send(input logic [7:0] b);
    @(negedge clk_50M);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    @(negedge clk_50M);
    i_rx_valid = 1'b0;
  endtask

  // Watch a ramp until HOLD or IDLE, recording step sizes and direction flips.
  task automatic settle(input int max_cyc, output int l_chg, output int r_chg,
                        output int bad_step, output int flips, output int flip_bad);
    int pl, pr, pd, d;
    l_chg = 0; r_chg = 0; bad_step = 0; flips = 0; flip_bad = 0;
    pl = int'(o_l_duty); pr = int'(o_r_duty); pd = int'(o_dir);
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk_50M);
      if (int'(o_l_duty) != pl) begin
        l_chg++;
        d = int'(o_l_duty) - pl;
        if (d != 5 && d != -5) bad_step++;
      end
      if (int'(o_r_duty) != pr) begin
        r_chg++;
        d = int'(o_r_duty) - pr;
        if (d != 5 && d != -5) bad_step++;
      end
      if (int'(o_dir) != pd) begin
        flips++;
        if (o_l_duty != 8'd0 || o_r_duty != 8'd0) flip_bad++;
      end
      pl = int'(o_l_duty); pr = int'(o_r_duty); pd = int'(o_dir);
      if (o_state == 2'd2 || o_state == 2'd0) break;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_l"}, o_l_duty, 0);
    check_eq({tag, "_r"}, o_r_duty, 0);
    check_eq({tag, "_dir"}, o_dir, 1);
    check_eq({tag, "_txs"}, o_tx_start, 0);
    check_eq({tag, "_txd"}, o_tx_data, 0);
    check_eq({tag, "_led"}, o_led, 0);
    check_eq({tag, "_st"}, o_state, 0);
  endtask

  initial begin
    int lc, rc, bad, fl, flb, pulses, cyc, found;
    logic [7:0] seen;

    repeat (3) @(negedge clk_50M);
    check_reset_vals("rst");
    rst_n = 1'b1;
    repeat (2) @(negedge clk_50M);

    // W from IDLE
    send(8'h57);
    check_eq("w_txs", o_tx_start, 1);
    check_eq("w_txd", o_tx_data, 8'h57);
    check_eq("w_st", o_state, 1);
    check_eq("w_led", o_led, 5'b01000);
    settle(300, lc, rc, bad, fl, flb);
    check_eq("w_lchg", lc, 20);
    check_eq("w_rchg", rc, 20);
    check_eq("w_bad", bad, 0);
    check_eq("w_l", o_l_duty, 100);
    check_eq("w_r", o_r_duty, 100);
    check_eq("w_hold", o_state, 2);
    check_eq("w_dir", o_dir, 1);

    // lower-case a in HOLD
    send(8'h61);
    check_eq("a_txs", o_tx_start, 1);
    check_eq("a_txd", o_tx_data, 8'h41);
    check_eq("a_led", o_led, 5'b00100);
    settle(300, lc, rc, bad, fl, flb);
    check_eq("a_lchg", lc, 15);
    check_eq("a_rchg", rc, 0);
    check_eq("a_bad", bad, 0);
    check_eq("a_l", o_l_duty, 25);
    check_eq("a_r", o_r_duty, 100);
    check_eq("a_hold", o_state, 2);

    send(8'h57);
    settle(300, lc, rc, bad, fl, flb);
    check_eq("w2_l", o_l_duty, 100);
    check_eq("w2_lchg", lc, 15);

    // X from {100,100}: brake, flip, ramp to 50
    send(8'h58);
    check_eq("x_st", o_state, 3);
    check_eq("x_dir0", o_dir, 1);
    check_eq("x_txd", o_tx_data, 8'h58);
    check_eq("x_led", o_led, 5'b10000);
    settle(400, lc, rc, bad, fl, flb);
    check_eq("x_lchg", lc, 30);
    check_eq("x_rchg", rc, 30);
    check_eq("x_bad", bad, 0);
    check_eq("x_flips", fl, 1);
    check_eq("x_flipbad", flb, 0);
    check_eq("x_dir", o_dir, 0);
    check_eq("x_l", o_l_duty, 50);
    check_eq("x_r", o_r_duty, 50);
    check_eq("x_hold", o_state, 2);

    // W back to forward through a full brake
    send(8'h57);
    check_eq("wr_st", o_state, 3);
    settle(400, lc, rc, bad, fl, flb);
    check_eq("wr_lchg", lc, 30);
    check_eq("wr_flips", fl, 1);
    check_eq("wr_flipbad", flb, 0);
    check_eq("wr_dir", o_dir, 1);
    check_eq("wr_l", o_l_duty, 100);
    check_eq("wr_hold", o_state, 2);

    // X then W mid-brake aborts the brake
    send(8'h58);
    repeat (20) @(negedge clk_50M);
    check_eq("ab_brk", o_state, 3);
    check_eq("ab_dir", o_dir, 1);
    check_eq("ab_partial", int'(o_l_duty < 8'd100 && o_l_duty > 8'd0), 1);
    send(8'h57);
    check_eq("ab_st", o_state, 1);
    check_eq("ab_dir2", o_dir, 1);
    settle(300, lc, rc, bad, fl, flb);
    check_eq("ab_flips", fl, 0);
    check_eq("ab_bad", bad, 0);
    check_eq("ab_l", o_l_duty, 100);
    check_eq("ab_r", o_r_duty, 100);
    check_eq("ab_hold", o_state, 2);

    // unknown byte while transmitter busy
    i_tx_ready = 1'b0;
    send(8'h31);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      if (o_tx_start) pulses++;
      @(negedge clk_50M);
    end
    check_eq("unk_busy", pulses, 0);
    i_tx_ready = 1'b1;
    seen = 8'd0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_50M);
      if (o_tx_start) begin
        pulses++;
        seen = o_tx_data;
      end
    end
    check_eq("unk_pulses", pulses, 1);
    check_eq("unk_txd", seen, 8'h3F);
    check_eq("unk_l", o_l_duty, 100);
    check_eq("unk_r", o_r_duty, 100);
    check_eq("unk_led", o_led, 5'b01000);
    check_eq("unk_st", o_state, 2);

    // W then silence: watchdog stop
    send(8'h57);
    check_eq("wd_ack", o_tx_data, 8'h57);
    cyc = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk_50M);
      cyc++;
      if (o_tx_start) break;
    end
    check_eq("wd_cyc", cyc, 400);
    check_eq("wd_txd", o_tx_data, 8'h21);
    check_eq("wd_st", o_state, 1);
    settle(300, lc, rc, bad, fl, flb);
    check_eq("wd_lchg", lc, 20);
    check_eq("wd_l", o_l_duty, 0);
    check_eq("wd_r", o_r_duty, 0);
    check_eq("wd_idle", o_state, 0);
    pulses = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk_50M);
      if (o_tx_start) pulses++;
    end
    check_eq("wd_once", pulses, 0);
    check_eq("wd_idle2", o_state, 0);

    // reset mid-ramp
    send(8'h57);
    found = 0;
    for (int i = 0; i < 200; i++) begin
      if (o_l_duty == 8'd35) begin
        found = 1;
        break;
      end
      @(negedge clk_50M);
    end
    check_eq("mr_found35", found, 1);
    rst_n = 1'b0;
    #1;
    check_reset_vals("mr");
    repeat (3) @(negedge clk_50M);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_50M);
      if (o_tx_start) pulses++;
    end
    check_eq("mr_notx", pulses, 0);
    check_eq("mr_st", o_state, 0);
    check_eq("mr_l", o_l_duty, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
